// File: rtl/divider_datapath.sv
// Register/arithmetic datapath of the non-restoring divider: holds Q, R, M and the
// iteration counter, and reports sign_R/done back to the control FSM.
module divider_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic             sub_en,
  input  logic             add_en,
  input  logic             count_en,
  input  logic             final_add,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             sign_R,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  logic [WIDTH+1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH+1:0] m_ext, r_sum, r_diff;

  assign m_ext  = {2'b00, m_q};
  assign r_sum  = r_q + m_ext;
  assign r_diff = r_q - m_ext;

  // Fixed priority keeps behaviour deterministic if strobes ever overlap.
  always_comb begin
    r_d   = r_q;
    q_d   = q_q;
    m_d   = m_q;
    dbz_d = dbz_q;
    if (load) begin
      q_d   = dividend;
      m_d   = divisor;
      r_d   = '0;
      dbz_d = (divisor == '0);
    end else if (shift_en) begin
      r_d = {r_q[WIDTH:0], q_q[WIDTH-1]};
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end else if (sub_en) begin
      r_d    = r_diff;
      q_d[0] = ~r_diff[WIDTH+1];
    end else if (add_en) begin
      r_d    = r_sum;
      q_d[0] = ~r_sum[WIDTH+1];
    end else if (final_add) begin
      if (r_q[WIDTH+1]) r_d = r_sum;
    end
  end

  // Counter saturates at WIDTH-1 so done holds until the next load.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      q_q   <= q_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end

  assign sign_R      = r_q[WIDTH+1];
  assign done        = (cnt_q == CntMax);
  assign quotient    = q_q;
  assign remainder   = r_q[WIDTH-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_datapath.sv
// Bench for divider_datapath: emulates the control FSM sequence and checks results
// against fixed vectors and a plain-arithmetic division model.
module tb_divider_datapath;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         load, shift_en, sub_en, add_en, count_en, final_add;
  logic [W-1:0] dividend, divisor;
  logic         sign_R, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;
  logic sign_pre_final;

  divider_datapath #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .shift_en    (shift_en),
    .sub_en      (sub_en),
    .add_en      (add_en),
    .count_en    (count_en),
    .final_add   (final_add),
    .dividend    (dividend),
    .divisor     (divisor),
    .sign_R      (sign_R),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dbz;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_strobes();
    load = 1'b0; shift_en = 1'b0; sub_en = 1'b0;
    add_en = 1'b0; count_en = 1'b0; final_add = 1'b0;
  endtask

  // Apply the current strobes across one rising edge, then release them.
  task automatic cyc();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    load     = 1'b1;
    cyc();
  endtask

  // One SHIFT, OP, COUNT iteration as the control FSM would sequence it.
  task automatic do_iter(input int it, input bit chk_done, input bit chk_sign0);
    shift_en = 1'b1;
    cyc();
    if (sign_R) add_en = 1'b1;
    else        sub_en = 1'b1;
    cyc();
    if (chk_sign0) chk("sign_R_stays_0", int'(sign_R), 0);
    if (chk_done) chk($sformatf("done_in_count_%0d", it), int'(done), (it == W) ? 1 : 0);
    count_en = 1'b1;
    cyc();
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit chk_done, input bit chk_sign0);
    do_load(a, b);
    for (int it = 1; it <= int'(W); it++) do_iter(it, chk_done, chk_sign0);
    sign_pre_final = sign_R;
    final_add = 1'b1;
    cyc();
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] eq,
                            input logic [W-1:0] er, input logic edbz);
    chk({tag, "_quotient"},  int'(quotient),    int'(eq));
    chk({tag, "_remainder"}, int'(remainder),   int'(er));
    chk({tag, "_dbz"},       int'(div_by_zero), int'(edbz));
  endtask

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    clear_strobes();
    dividend = '0;
    divisor  = '0;

    // Reset held for two cycles.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_result("reset", 8'd0, 8'd0, 1'b0);
    chk("reset_done", int'(done), 0);
    chk("reset_sign_R", int'(sign_R), 0);

    vecs[0] = '{a: 8'd100, b: 8'd7,   exp_q: 8'd14,  exp_r: 8'd2,   exp_dbz: 1'b0};
    vecs[1] = '{a: 8'd5,   b: 8'd9,   exp_q: 8'd0,   exp_r: 8'd5,   exp_dbz: 1'b0};
    vecs[2] = '{a: 8'd255, b: 8'd255, exp_q: 8'd1,   exp_r: 8'd0,   exp_dbz: 1'b0};
    vecs[3] = '{a: 8'd255, b: 8'd1,   exp_q: 8'd255, exp_r: 8'd0,   exp_dbz: 1'b0};
    vecs[4] = '{a: 8'd200, b: 8'd0,   exp_q: 8'd255, exp_r: 8'd200, exp_dbz: 1'b1};
    vecs[5] = '{a: 8'd48,  b: 8'd5,   exp_q: 8'd9,   exp_r: 8'd3,   exp_dbz: 1'b0};
    vecs[6] = '{a: 8'd0,   b: 8'd3,   exp_q: 8'd0,   exp_r: 8'd0,   exp_dbz: 1'b0};
    vecs[7] = '{a: 8'd128, b: 8'd128, exp_q: 8'd1,   exp_r: 8'd0,   exp_dbz: 1'b0};

    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].a, vecs[i].b, (i == 0), (vecs[i].b == '0));
      if (i == 1) chk("5div9_sign_before_final", int'(sign_pre_final), 1);
      repeat (2) cyc();  // results must hold while idle
      chk_result($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dbz);
    end

    // Randomised operands against plain integer division.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = (i % 10 == 9) ? '0 : W'($urandom_range(1, 255));
      if (rb == '0) begin
        mq = '1;
        mr = ra;
      end else begin
        mq = ra / rb;
        mr = ra % rb;
      end
      run_div(ra, rb, 1'b0, 1'b0);
      chk_result($sformatf("rand_%0d_div_%0d", ra, rb), mq, mr, (rb == '0));
    end

    // Asynchronous reset part-way through 100/7.
    do_load(8'd100, 8'd7);
    for (int it = 1; it <= 3; it++) do_iter(it, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_result("midreset", 8'd0, 8'd0, 1'b0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_sign_R", int'(sign_R), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_div(8'd48, 8'd5, 1'b1, 1'b0);
    chk_result("after_reset_48div5", 8'd9, 8'd3, 1'b0);

    // final_add with nonnegative R leaves the result alone.
    final_add = 1'b1;
    cyc();
    chk_result("extra_final_add", 8'd9, 8'd3, 1'b0);

    // load beats count_en; counter then needs seven pulses to reach done.
    dividend = 8'd77;
    divisor  = 8'd4;
    load     = 1'b1;
    count_en = 1'b1;
    cyc();
    chk("load_count_done", int'(done), 0);
    chk("load_count_q", int'(quotient), 77);
    for (int k = 1; k <= 7; k++) begin
      count_en = 1'b1;
      cyc();
      chk($sformatf("count_pulse_%0d_done", k), int'(done), (k == 7) ? 1 : 0);
    end
    for (int k = 1; k <= 3; k++) begin
      count_en = 1'b1;
      cyc();
      chk($sformatf("saturate_%0d_done", k), int'(done), 1);
    end

    // shift_en outranks sub_en: only the shift happens.
    shift_en = 1'b1;
    sub_en   = 1'b1;
    cyc();
    chk("prio_shift_q", int'(quotient), 154);
    chk("prio_shift_r", int'(remainder), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_datapath.md
Name: divider_datapath

Overview:
- Register/arithmetic datapath for the 8-bit non-restoring divider.
- Consumes the one-hot control strobes from the divider control FSM: load, shift_en, add_en, sub_en, count_en and final_add.
- Returns the status the FSM branches on: sign_R and done.
- Holds dividend/quotient (Q), partial remainder (R), divisor (M) and the iteration counter; presents the unsigned quotient and remainder to the ALU result mux.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits; R is WIDTH+2 bits, counter is clog2(WIDTH) bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; clears all registers while low.
- load  input  1  capture operands, clear R and counter.
- shift_en  input  1  shift {R,Q} left by one.
- sub_en  input  1  R <= R - M; set Q[0].
- add_en  input  1  R <= R + M; set Q[0].
- count_en  input  1  advance iteration counter.
- final_add  input  1  remainder correction step.
- dividend  input  WIDTH  unsigned dividend, sampled on load.
- divisor  input  WIDTH  unsigned divisor, sampled on load.
- sign_R  output  1  R[WIDTH+1], the sign of the partial remainder.
- done  output  1  high when count == WIDTH-1.
- quotient  output  WIDTH  Q register.
- remainder  output  WIDTH  R[WIDTH-1:0].
- div_by_zero  output  1  registered flag: divisor == 0 at last load.

Behaviour:
- Reset (reset low, asynchronous, any time including mid-division):
  - R, Q, M, count and div_by_zero go to 0 immediately.
  - Outputs read sign_R=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- All register updates occur on the rising clk edge; sign_R, done, quotient and remainder are pure functions of registers, with no combinational path from the strobes.
- R/Q/M update priority when more than one strobe is high (the FSM never does this; the priority guarantees determinism): load > shift_en > sub_en > add_en > final_add. Lower-priority strobes are ignored that cycle.
- load:
  - Q <= dividend, M <= divisor, R <= 0, count <= 0.
  - div_by_zero <= (divisor == 0).
- shift_en: {R,Q} <= {R,Q} << 1. R[0] takes the old Q[WIDTH-1]; Q[0] becomes 0.
- sub_en:
  - R <= R - zero-extended M, computed in WIDTH+2 bits, modulo 2^(WIDTH+2).
  - Q[0] <= ~(new R sign bit).
- add_en: R <= R + zero-extended M; Q[0] <= ~(new R sign bit).
- final_add:
  - If R[WIDTH+1]==1, R <= R + M; otherwise R is unchanged.
  - Q is never altered by final_add.
- Width rule: R is WIDTH+2 bits so that 2R stays in the signed range and a shift never flips the sign. The FSM's add/sub decision taken from sign_R after SHIFT is therefore the correct non-restoring decision.
- Counter:
  - load clears the counter; load wins over count_en.
  - count_en increments the counter, saturating at WIDTH-1 with no wrap.
  - done is combinational: done = (count == WIDTH-1). It stays high until the next load or reset.
- Iteration timing:
  - The FSM samples done in its COUNT state, before the increment lands, so exactly WIDTH shift/op iterations are performed.
  - For WIDTH=8: after LOAD plus 8×(SHIFT, OP, COUNT) plus FINAL_CORRECT, the result is valid on the cycle the FSM enters DONE.
- Result hold: quotient, remainder and div_by_zero hold their values after final_add until the next load or reset.
- Divide by zero needs no special datapath action. Every step subtracts 0, so R never goes negative and Q fills with 1s. The result is quotient = 2^WIDTH-1 and remainder = dividend, with div_by_zero=1.
- Invariant after final_add with divisor != 0:
  - dividend = quotient*divisor + remainder.
  - 0 <= remainder < divisor.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> all outputs 0, done=0, sign_R=0.
- 100/7, driven by the FSM sequence (load, 8×shift/op/count, final_add) -> quotient=14, remainder=2, div_by_zero=0. done rises exactly when count reaches 7, i.e. in the 8th COUNT state.
- 5/9, then 255/255, then 255/1 -> (0,5), (1,0), (255,0). After 5/9, sign_R=1 before final_add and remainder=5 after it.
- 200/0 -> quotient=255, remainder=200, div_by_zero=1; sign_R stays 0 through every iteration.
- Mid-operation reset: start 100/7, drive reset=0 asynchronously between clock edges after the 3rd count_en -> outputs and counter read 0 immediately. A fresh 48/5 then yields quotient=9, remainder=3.
- Strobe priority and saturation:
  - load and count_en in the same cycle -> count=0.
  - Extra count_en pulses after done -> count holds at 7, done stays 1.
  - final_add when R is nonnegative -> remainder unchanged.
